// File: rtl/axi_interconnect_rd.sv
// Read-side AXI master: fixed-length AR bursts streamed into the channel 1 FIFO.
// Optional playback job compiled in with `define AXI_RD_PLAYBACK_EN.
module axi_interconnect_rd #(
  parameter int MEM_ROW_WIDTH    = 15,
  parameter int MEM_COLUMN_WIDTH = 10,
  parameter int MEM_BANK_WIDTH   = 3,
  parameter int CTRL_ADDR_WIDTH  = MEM_ROW_WIDTH + MEM_BANK_WIDTH
                                   + MEM_COLUMN_WIDTH,
  parameter int DQ_WIDTH         = 32,
  parameter int BURST_LEN        = 16,
  parameter int IDLE_ADDR        = 14400,
  parameter int RECORD_BASE      = 264400
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rd_start,
  input  logic [CTRL_ADDR_WIDTH-1:0] axi_awaddr,
  input  logic                       play_start,
  input  logic [CTRL_ADDR_WIDTH-1:0] record_end_addr,
  input  logic                       channel1_wready,
  output logic                       channel1_wr_en,
  output logic [DQ_WIDTH*8-1:0]      channel1_wdata,
  output logic [CTRL_ADDR_WIDTH-1:0] axi_araddr,
  output logic                       axi_arvalid,
  input  logic                       axi_arready,
  input  logic [DQ_WIDTH*8-1:0]      axi_rdata,
  input  logic                       axi_rvalid,
  input  logic                       axi_rlast,
  output logic                       rd_busy,
  output logic                       rd_done,
  output logic                       rd_err
);

  localparam int AW = CTRL_ADDR_WIDTH;
  localparam int CW = $clog2(BURST_LEN) + 1;

  typedef enum logic [1:0] {
    IDLE,
    AXI_ARADDR,
    AXI_RDATA,
    DONE
  } state_t;

  state_t        state;
  state_t        next;
  logic          rd_start_q;
  logic          wready_m;
  logic          wready_s;
  logic [AW:0]   limit;
  logic [CW-1:0] beat_cnt;
  logic          start_mfcc;
  logic          start_play;
  logic          in_range;
  logic          ar_hs;

  assign start_mfcc = rd_start & ~rd_start_q;
  assign ar_hs      = axi_arvalid & axi_arready;

`ifdef AXI_RD_PLAYBACK_EN
  assign start_play = play_start & ~start_mfcc;
`else
  logic unused_play;
  assign unused_play = ^{play_start, record_end_addr};
  assign start_play  = 1'b0;
`endif

  // A borrow out of the MFCC limit subtraction means nothing to read.
  assign in_range = ~limit[AW] & ({1'b0, axi_araddr} <= limit);

  assign channel1_wr_en = (state == AXI_RDATA) & axi_rvalid;
  assign channel1_wdata = axi_rdata;
  assign rd_done        = (state == DONE);

  always_comb begin
    next = state;
    unique case (state)
      IDLE: begin
        if (rd_busy) begin
          if (!in_range)
            next = DONE;
          else if (wready_s)
            next = AXI_ARADDR;
        end
      end
      AXI_ARADDR: if (ar_hs) next = AXI_RDATA;
      AXI_RDATA:  if (axi_rvalid && axi_rlast) next = IDLE;
      DONE:       next = IDLE;
      default:    next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rd_start_q  <= 1'b0;
      wready_m    <= 1'b0;
      wready_s    <= 1'b0;
      limit       <= '0;
      beat_cnt    <= '0;
      axi_araddr  <= '0;
      axi_arvalid <= 1'b0;
      rd_busy     <= 1'b0;
      rd_err      <= 1'b0;
    end else begin
      state      <= next;
      rd_start_q <= rd_start;
      wready_m   <= channel1_wready;
      wready_s   <= wready_m;
      unique case (state)
        IDLE: begin
          if (!rd_busy) begin
            if (start_mfcc) begin
              axi_araddr <= '0;
              limit      <= {1'b0, axi_awaddr}
                            - (AW+1)'(IDLE_ADDR);
              rd_busy    <= 1'b1;
            end else if (start_play) begin
              axi_araddr <= AW'(RECORD_BASE);
              limit      <= {1'b0, record_end_addr};
              rd_busy    <= 1'b1;
            end
          end else if (next == AXI_ARADDR) begin
            axi_arvalid <= 1'b1;
          end
        end
        AXI_ARADDR: begin
          if (ar_hs) begin
            axi_arvalid <= 1'b0;
            axi_araddr  <= axi_araddr + AW'(BURST_LEN * 8);
          end
        end
        AXI_RDATA: begin
          if (axi_rvalid) begin
            if (axi_rlast) begin
              beat_cnt <= '0;
              if (beat_cnt != CW'(BURST_LEN - 1))
                rd_err <= 1'b1;
            end else begin
              if (beat_cnt == CW'(BURST_LEN - 1))
                rd_err <= 1'b1;
              if (beat_cnt != '1)
                beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        DONE: rd_busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
